// File: rtl/ysyx_23060203_axi_rd_sched.sv
// Shares one AXI4 read port between IFU and LSU, one outstanding transaction at a time.
// Latency: 1 cycle arbitration in IDLE, then AR and R pass through combinationally.
// Backpressure: m_rready follows the winner's rready; requests arriving while busy wait.
//
// Ports:
//   clock, reset                 clock and asynchronous active-high reset
//   ifu_ar*/ifu_r*               IFU read requester (AR in, R out)
//   lsu_ar*/lsu_r*               LSU read requester (AR in, R out)
//   m_ar*/m_r*                   downstream AXI4 read master port (burst fixed to INCR)
//   busy                         registered, high whenever the FSM is not IDLE
// Optional feature: define YSYX_23060203_ARB_RR_EN for round-robin arbitration;
// otherwise fixed priority with LSU winning a tie.
// TIMEOUT cycles in R without a handshake produce a SLVERR beat; TIMEOUT = 0 disables it.
module ysyx_23060203_axi_rd_sched #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 1024
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              ifu_arvalid,
   output logic              ifu_arready,
   input  logic [ADDR_W-1:0] ifu_araddr,
   input  logic [7:0]        ifu_arlen,
   input  logic [2:0]        ifu_arsize,
   output logic              ifu_rvalid,
   input  logic              ifu_rready,
   output logic [DATA_W-1:0] ifu_rdata,
   output logic [1:0]        ifu_rresp,
   output logic              ifu_rlast,
   input  logic              lsu_arvalid,
   output logic              lsu_arready,
   input  logic [ADDR_W-1:0] lsu_araddr,
   input  logic [7:0]        lsu_arlen,
   input  logic [2:0]        lsu_arsize,
   output logic              lsu_rvalid,
   input  logic              lsu_rready,
   output logic [DATA_W-1:0] lsu_rdata,
   output logic [1:0]        lsu_rresp,
   output logic              lsu_rlast,
   output logic              m_arvalid,
   input  logic              m_arready,
   output logic [ADDR_W-1:0] m_araddr,
   output logic [7:0]        m_arlen,
   output logic [2:0]        m_arsize,
   output logic [1:0]        m_arburst,
   input  logic              m_rvalid,
   output logic              m_rready,
   input  logic [DATA_W-1:0] m_rdata,
   input  logic [1:0]        m_rresp,
   input  logic              m_rlast,
   output logic              busy
);

   // The watchdog counts 0 .. TIMEOUT-1 and fires on the cycle after TIMEOUT-1.
   localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_AR,
      S_R,
      S_ERR,
      S_DRAIN
   } state_e;

   state_e            state_q, state_d;
   logic              grant_q, grant_d;   // 1 = LSU owns the port, 0 = IFU
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        len_q, len_d;
   logic [2:0]        size_q, size_d;
   logic [WD_W-1:0]   wdog_q, wdog_d;
   logic              busy_q, busy_d;

   logic              pick_lsu;
   logic              win_rready;
   logic              ar_ack;
   logic              r_vld;
   logic              r_last;
   logic [DATA_W-1:0] r_dat;
   logic [1:0]        r_resp;

   assign win_rready = grant_q ? lsu_rready : ifu_rready;

`ifdef YSYX_23060203_ARB_RR_EN
   // rr_q = 1 favours the LSU on a tie; flips to the loser after every transaction.
   logic rr_q, rr_d;
   logic txn_done;

   assign pick_lsu = (ifu_arvalid & lsu_arvalid) ? rr_q : lsu_arvalid;
   assign txn_done = ((state_q == S_R) & m_rvalid & win_rready & m_rlast) |
                     ((state_q == S_DRAIN) & m_rvalid & m_rlast);

   always_comb begin
      rr_d = rr_q;
      if (txn_done) begin
         rr_d = ~grant_q;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rr_q <= 1'b0;
      end else begin
         rr_q <= rr_d;
      end
   end
`else
   assign pick_lsu = lsu_arvalid;
`endif

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      addr_d    = addr_q;
      len_d     = len_q;
      size_d    = size_q;
      wdog_d    = wdog_q;
      m_arvalid = 1'b0;
      m_rready  = 1'b0;
      ar_ack    = 1'b0;
      r_vld     = 1'b0;
      r_dat     = '0;
      r_resp    = 2'b00;
      r_last    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (ifu_arvalid | lsu_arvalid) begin
               grant_d = pick_lsu;
               addr_d  = pick_lsu ? lsu_araddr : ifu_araddr;
               len_d   = pick_lsu ? lsu_arlen  : ifu_arlen;
               size_d  = pick_lsu ? lsu_arsize : ifu_arsize;
               state_d = S_AR;
            end
         end
         S_AR: begin
            m_arvalid = 1'b1;
            if (m_arready) begin
               ar_ack  = 1'b1;
               wdog_d  = '0;
               state_d = S_R;
            end
         end
         S_R: begin
            m_rready = win_rready;
            r_vld    = m_rvalid;
            r_dat    = m_rdata;
            r_resp   = m_rresp;
            r_last   = m_rlast;
            if (m_rvalid & win_rready) begin
               wdog_d = '0;
               if (m_rlast) begin
                  state_d = S_IDLE;
               end
            end else if (TIMEOUT != 0) begin
               if (wdog_q == WD_W'(TIMEOUT - 1)) begin
                  state_d = S_ERR;
               end else begin
                  wdog_d = wdog_q + WD_W'(1);
               end
            end
         end
         S_ERR: begin
            // Synthesised SLVERR beat; the slave is not allowed to complete now.
            r_vld  = 1'b1;
            r_resp = 2'b10;
            r_last = 1'b1;
            if (win_rready) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // Swallow any late beats until the slave finally ends the burst.
            m_rready = 1'b1;
            if (m_rvalid & m_rlast) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         grant_q <= 1'b0;
         addr_q  <= '0;
         len_q   <= '0;
         size_q  <= '0;
         wdog_q  <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         size_q  <= size_d;
         wdog_q  <= wdog_d;
         busy_q  <= busy_d;
      end
   end

   assign ifu_arready = ar_ack & ~grant_q;
   assign lsu_arready = ar_ack & grant_q;
   assign ifu_rvalid  = r_vld & ~grant_q;
   assign lsu_rvalid  = r_vld & grant_q;
   assign ifu_rdata   = grant_q ? '0 : r_dat;
   assign lsu_rdata   = grant_q ? r_dat : '0;
   assign ifu_rresp   = grant_q ? 2'b00 : r_resp;
   assign lsu_rresp   = grant_q ? r_resp : 2'b00;
   assign ifu_rlast   = r_last & ~grant_q;
   assign lsu_rlast   = r_last & grant_q;

   assign m_araddr  = addr_q;
   assign m_arlen   = len_q;
   assign m_arsize  = size_q;
   assign m_arburst = 2'b01;
   assign busy      = busy_q;

endmodule

// File: tb/tb_ysyx_23060203_axi_rd_sched.sv
// Bench for the IFU/LSU read scheduler: randomized transactions against a
// transaction-level model (arrival order, tie rule, pointer, beat data).
// Requesters and slave are driven at negedge and sampled 1 time unit later.
module tb_ysyx_23060203_axi_rd_sched;

   localparam int TO = 8;
`ifdef YSYX_23060203_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready, ifu_rlast;
   logic [31:0] ifu_araddr, ifu_rdata;
   logic [7:0]  ifu_arlen;
   logic [2:0]  ifu_arsize;
   logic [1:0]  ifu_rresp;
   logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready, lsu_rlast;
   logic [31:0] lsu_araddr, lsu_rdata;
   logic [7:0]  lsu_arlen;
   logic [2:0]  lsu_arsize;
   logic [1:0]  lsu_rresp;
   logic        m_arvalid, m_arready, m_rvalid, m_rready, m_rlast, busy;
   logic [31:0] m_araddr, m_rdata;
   logic [7:0]  m_arlen;
   logic [2:0]  m_arsize;
   logic [1:0]  m_arburst, m_rresp;

   int n_checks = 0;
   int n_fail   = 0;
   bit ifu_active = 1'b0;
   bit lsu_active = 1'b0;
   bit rr_model   = 1'b0;     // 1 = LSU favoured on the next tie
   logic [31:0] ar_addr_q[$];
   logic [2:0]  ar_size_q[$];

   always #5 clock = ~clock;

   ysyx_23060203_axi_rd_sched #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
      .clock(clock), .reset(reset),
      .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready), .ifu_araddr(ifu_araddr),
      .ifu_arlen(ifu_arlen), .ifu_arsize(ifu_arsize), .ifu_rvalid(ifu_rvalid),
      .ifu_rready(ifu_rready), .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rlast(ifu_rlast),
      .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready), .lsu_araddr(lsu_araddr),
      .lsu_arlen(lsu_arlen), .lsu_arsize(lsu_arsize), .lsu_rvalid(lsu_rvalid),
      .lsu_rready(lsu_rready), .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rlast(lsu_rlast),
      .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
      .m_arsize(m_arsize), .m_arburst(m_arburst), .m_rvalid(m_rvalid), .m_rready(m_rready),
      .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .busy(busy)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] beat_data(input logic [31:0] a, input int b);
      return a ^ (32'h0101_0101 * 32'(b + 1));
   endfunction

   task automatic check_quiet(input string p);
      check({p, "_busy"}, busy, 0);
      check({p, "_m_arvalid"}, m_arvalid, 0);
      check({p, "_m_rready"}, m_rready, 0);
      check({p, "_arready"}, {ifu_arready, lsu_arready}, 0);
      check({p, "_rvalid"}, {ifu_rvalid, lsu_rvalid}, 0);
      check({p, "_rdata"}, {ifu_rdata, lsu_rdata}, 0);
      check({p, "_rresp_rlast"}, {ifu_rresp, lsu_rresp, ifu_rlast, lsu_rlast}, 0);
   endtask

   // Cycle-level invariants that hold for any legal traffic.
   always @(negedge clock) begin
      #2;
      if (!reset) begin
         check("rvalid_excl", ifu_rvalid & lsu_rvalid, 0);
         check("arready_excl", ifu_arready & lsu_arready, 0);
         check("ifu_stray", ifu_rvalid & ~ifu_active, 0);
         check("lsu_stray", lsu_rvalid & ~lsu_active, 0);
         if (m_arvalid) check("arburst", m_arburst, 2'b01);
         if (m_arvalid | ifu_rvalid | lsu_rvalid) check("busy_hi", busy, 1);
      end
   end

   task automatic requester(input bit who, input int dly, input logic [31:0] a,
                            input logic [7:0] len, input logic [2:0] sz,
                            input int stall, input bit err);
      int cnt, b, sc, lat, lim;
      logic rv, rd_rdy, rl;
      logic [31:0] rd;
      logic [1:0] rs;
      repeat (dly + 1) @(negedge clock);
      if (who) begin
         lsu_arvalid = 1; lsu_araddr = a; lsu_arlen = len; lsu_arsize = sz; lsu_active = 1;
      end else begin
         ifu_arvalid = 1; ifu_araddr = a; ifu_arlen = len; ifu_arsize = sz; ifu_active = 1;
      end
      cnt = 0;
      #1;
      while (!(who ? lsu_arready : ifu_arready) && cnt < 300) begin
         @(negedge clock); #1; cnt++;
      end
      if (cnt >= 300) check("ar_wait_tmo", 1, 0);
      @(negedge clock);
      if (who) lsu_arvalid = 0; else ifu_arvalid = 0;
      b = 0; sc = 0; lat = 0; cnt = 0;
      lim = err ? 0 : int'(len);
      while (b <= lim && cnt < 300) begin
         rd_rdy = (sc >= stall);
         if (who) lsu_rready = rd_rdy; else ifu_rready = rd_rdy;
         #1;
         rv = who ? lsu_rvalid : ifu_rvalid;
         rd = who ? lsu_rdata  : ifu_rdata;
         rs = who ? lsu_rresp  : ifu_rresp;
         rl = who ? lsu_rlast  : ifu_rlast;
         if (rv) begin
            if (rd_rdy) begin
               if (err) begin
                  check("err_rresp", rs, 2'b10);
                  check("err_rdata", rd, 0);
                  check("err_rlast", rl, 1);
                  check("err_mrready", m_rready, 0);
                  check("wdog_lat", lat, TO);
               end else begin
                  check("rdata", rd, beat_data(a, b));
                  check("rresp", rs, 0);
                  check("rlast", rl, b == int'(len));
               end
               b++;
            end else begin
               check("stall_mrready", m_rready, 0);
            end
         end else if (b == 0) begin
            lat++;
         end
         sc++; cnt++;
         @(negedge clock);
      end
      if (cnt >= 300) check("r_wait_tmo", 1, 0);
      if (who) begin lsu_rready = 0; lsu_active = 0; end
      else begin ifu_rready = 0; ifu_active = 0; end
   endtask

   task automatic drive_beat(input logic [31:0] d, input bit last);
      int cnt;
      m_rvalid = 1; m_rdata = d; m_rlast = last; m_rresp = 2'b00;
      cnt = 0;
      #1;
      while (!m_rready && cnt < 300) begin
         @(negedge clock); #1; cnt++;
      end
      if (cnt >= 300) check("slv_r_tmo", 1, 0);
      @(negedge clock);
      m_rvalid = 0; m_rlast = 0; m_rdata = 0;
   endtask

   task automatic slave_serve(input int ar_dly, input int r_dly, input bit err);
      int cnt;
      logic [31:0] a;
      logic [7:0] len;
      cnt = 0;
      @(negedge clock); #1;
      while (!m_arvalid && cnt < 300) begin
         @(negedge clock); #1; cnt++;
      end
      if (cnt >= 300) check("slv_ar_tmo", 1, 0);
      repeat (ar_dly) @(negedge clock);
      @(negedge clock);
      m_arready = 1;
      #1;
      a = m_araddr; len = m_arlen;
      ar_addr_q.push_back(a);
      ar_size_q.push_back(m_arsize);
      @(negedge clock);
      m_arready = 0;
      if (err) begin
         repeat (15) @(negedge clock);
         drive_beat(32'hDEAD_BEEF, 1'b1);
      end else begin
         for (int b = 0; b <= int'(len); b++) begin
            repeat (r_dly) @(negedge clock);
            drive_beat(beat_data(a, b), b == int'(len));
         end
      end
   endtask

   // mode: 1 = IFU only, 2 = LSU only, 3 = both. The earlier arrival wins;
   // same-cycle arrivals follow the tie rule.
   task automatic run_txn(input int mode, input int ifu_dly, input int lsu_dly,
                          input logic [31:0] ia, input logic [31:0] la,
                          input logic [7:0] il, input logic [7:0] ll,
                          input logic [2:0] is, input logic [2:0] ls,
                          input int ist, input int lst,
                          input int ar_dly, input int r_dly, input bit err);
      int n;
      bit first;
      bit order[2];
      n = (mode == 3) ? 2 : 1;
      if (mode == 1) first = 0;
      else if (mode == 2) first = 1;
      else if (ifu_dly < lsu_dly) first = 0;
      else if (lsu_dly < ifu_dly) first = 1;
      else first = RR ? rr_model : 1'b1;
      order[0] = first;
      order[1] = ~first;
      fork
         begin if (mode != 2) requester(0, ifu_dly, ia, il, is, ist, err); end
         begin if (mode != 1) requester(1, lsu_dly, la, ll, ls, lst, err); end
         begin for (int k = 0; k < n; k++) slave_serve(ar_dly, r_dly, err); end
      join
      for (int k = 0; k < n; k++) begin
         if (ar_addr_q.size() == 0) begin
            check("ar_missing", 1, 0);
         end else begin
            check("ar_addr_order", ar_addr_q.pop_front(), order[k] ? la : ia);
            check("ar_size", ar_size_q.pop_front(), order[k] ? ls : is);
         end
         rr_model = ~order[k];
      end
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      int mode;
      bit who;
      ifu_arvalid = 0; ifu_araddr = 0; ifu_arlen = 0; ifu_arsize = 0; ifu_rready = 0;
      lsu_arvalid = 0; lsu_araddr = 0; lsu_arlen = 0; lsu_arsize = 0; lsu_rready = 0;
      m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0; m_rlast = 0;

      repeat (2) @(negedge clock);
      #1 check_quiet("rst");
      @(negedge clock);
      reset = 0;
      #1 check_quiet("post_rst");

      // IFU alone, single beat, slave answers after 2 cycles.
      run_txn(1, 0, 0, 32'h3000_0000, 32'h0, 8'd0, 8'd0, 3'd2, 3'd2, 0, 0, 2, 2, 0);

      // Same-cycle requests, twice so the round-robin pointer is exercised.
      repeat (2) run_txn(3, 0, 0, 32'h8000_0100, 32'h8000_0200, 8'd1, 8'd1,
                         3'd2, 3'd1, 0, 0, 1, 1, 0);

      // LSU 4-beat burst with an IFU request arriving mid-transfer.
      run_txn(3, 3, 0, 32'h8000_1000, 32'h8000_2000, 8'd0, 8'd3, 3'd2, 3'd2, 0, 0, 0, 2, 0);

      // Silent slave: watchdog SLVERR, then a late beat is drained.
      who = 1'($urandom_range(0, 1));
      run_txn(who ? 2 : 1, 0, 0, 32'h9000_0000, 32'h9000_0040, 8'd2, 8'd2,
              3'd2, 3'd2, 0, 0, 1, 0, 1);
      #1 check("drain_idle", busy, 0);

      // Requester stalls 5 cycles while the slave holds its beat.
      run_txn(1, 0, 0, 32'hA000_0000, 32'h0, 8'd1, 8'd0, 3'd2, 3'd2, 5, 0, 0, 0, 0);
      run_txn(2, 0, 0, 32'h0, 32'hA000_0100, 8'd0, 8'd1, 3'd2, 3'd2, 0, 5, 1, 0, 0);

      // Reset while a beat is pending in R.
      @(negedge clock);
      ifu_arvalid = 1; ifu_araddr = 32'h4000_0040; ifu_arlen = 0; ifu_arsize = 2; ifu_active = 1;
      @(negedge clock);
      #1 check("e_m_arvalid", m_arvalid, 1);
      check("e_m_araddr", m_araddr, 32'h4000_0040);
      m_arready = 1;
      #1 check("e_arready", ifu_arready, 1);
      @(negedge clock);
      m_arready = 0; ifu_arvalid = 0; ifu_rready = 0;
      m_rvalid = 1; m_rdata = 32'h1234_5678; m_rlast = 1;
      #1 check("e_route_vld", ifu_rvalid, 1);
      check("e_route_dat", ifu_rdata, 32'h1234_5678);
      @(negedge clock);
      reset = 1;
      #1 check_quiet("e_rst");
      m_rvalid = 0; m_rdata = 0; m_rlast = 0;
      ifu_active = 0;
      rr_model = 0;
      repeat (2) @(negedge clock);
      reset = 0;
      run_txn(1, 0, 0, 32'h4000_0080, 32'h0, 8'd1, 8'd0, 3'd2, 3'd2, 0, 0, 1, 1, 0);

      // Randomized traffic.
      for (int i = 0; i < 24; i++) begin
         mode = $urandom_range(1, 3);
         run_txn(mode, $urandom_range(0, 2), $urandom_range(0, 2),
                 $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
                 8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)),
                 3'($urandom_range(0, 2)), 3'($urandom_range(0, 2)),
                 $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 2), $urandom_range(0, 2), 0);
      end

      repeat (3) @(negedge clock);
      #1 check("end_idle", busy, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
